// File: rtl/demux4x32_reg_if.sv
// Bus bundle for the registered 1-to-4 distributor.
// One producer-side valid/ready port and four consumer channels, each with its own
// word and delivered-transfer counter. The master modport is the environment that
// drives the producer and the consumers. The slave modport is the distributor itself.
interface demux4x32_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  // producer side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;

  // consumer side
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [CNT_W-1:0] xfer_cnt0;
  logic [CNT_W-1:0] xfer_cnt1;
  logic [CNT_W-1:0] xfer_cnt2;
  logic [CNT_W-1:0] xfer_cnt3;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid,
    input  out_data0, out_data1, out_data2, out_data3,
    input  xfer_cnt0, xfer_cnt1, xfer_cnt2, xfer_cnt3
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid,
    output out_data0, out_data1, out_data2, out_data3,
    output xfer_cnt0, xfer_cnt1, xfer_cnt2, xfer_cnt3
  );
endinterface

// File: rtl/demux4x32_reg.sv
// Registered 1-to-4 distributor.
// A word plus a 2-bit destination select is accepted over valid/ready and parked in
// the selected channel's one-entry output register. Every channel runs its own
// EMPTY/FULL machine, so a stalled consumer only blocks words aimed at its channel.
// A FULL channel that drains in the same cycle can take a new word at once,
// which sustains one word per cycle per channel.
module demux4x32_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  demux4x32_reg_if.slave   bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  // per-channel status gathered into flat vectors for the shared input path
  logic [3:0]         w_valid;
  logic [4*WIDTH-1:0] w_data_flat;
  logic [4*CNT_W-1:0] w_cnt_flat;

  logic               w_in_ready;
  logic               w_accept;

  // Readiness of the addressed channel only. Forced low while reset is asserted,
  // so nothing is accepted into a register that is being cleared.
  assign w_in_ready = clrn & (~w_valid[bus.in_sel] | bus.out_ready[bus.in_sel]);
  assign w_accept   = bus.in_valid & w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;

  assign bus.out_data0 = w_data_flat[0*WIDTH +: WIDTH];
  assign bus.out_data1 = w_data_flat[1*WIDTH +: WIDTH];
  assign bus.out_data2 = w_data_flat[2*WIDTH +: WIDTH];
  assign bus.out_data3 = w_data_flat[3*WIDTH +: WIDTH];

  assign bus.xfer_cnt0 = w_cnt_flat[0*CNT_W +: CNT_W];
  assign bus.xfer_cnt1 = w_cnt_flat[1*CNT_W +: CNT_W];
  assign bus.xfer_cnt2 = w_cnt_flat[2*CNT_W +: CNT_W];
  assign bus.xfer_cnt3 = w_cnt_flat[3*CNT_W +: CNT_W];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      chan_state_t      r_state;
      chan_state_t      w_state_next;
      logic             w_load;
      logic             w_acc;
      logic             w_drain;
      logic [WIDTH-1:0] r_data;
      logic [CNT_W-1:0] r_cnt;

      // A word addressed here is taken. A held word leaves when its consumer is ready.
      assign w_acc   = w_accept & (bus.in_sel == 2'(gi));
      assign w_drain = (r_state == FULL) & bus.out_ready[gi];

      // channel state register. Words held at reset are dropped, not delivered.
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          r_state <= EMPTY;
        end else begin
          r_state <= w_state_next;
        end
      end

      // Next state and load enable. A refill in the drain cycle keeps the channel FULL.
      always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
          EMPTY: begin
            if (w_acc) begin
              w_state_next = FULL;
              w_load       = 1'b1;
            end
          end
          FULL: begin
            if (w_acc) begin
              w_load = 1'b1;
            end else if (w_drain) begin
              w_state_next = EMPTY;
            end
          end
          default: begin
            w_state_next = EMPTY;
          end
        endcase
      end

      // Output word, written only on accept, so it is stable during a stall and kept after a drain.
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          r_data <= '0;
        end else if (w_load) begin
          r_data <= bus.in_data;
        end
      end

      // Delivered-word counter. It advances once per drain and wraps naturally at full scale.
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          r_cnt <= '0;
        end else if (w_drain) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_valid[gi]                    = (r_state == FULL);
      assign w_data_flat[gi*WIDTH +: WIDTH] = r_data;
      assign w_cnt_flat[gi*CNT_W +: CNT_W]  = r_cnt;
    end
  endgenerate

endmodule

// File: tb/tb_demux4x32_reg.sv
// Scoreboard bench for demux4x32_reg.
// One queue per channel holds accepted words. A word is pushed when the bench sees
// an accept and popped when the consumer drains it. A second instance with 4-bit
// counters shares the same stimulus and is used to check counter wrap.
module tb_demux4x32_reg;

  logic clk = 1'b0;
  logic clrn;

  always #5 clk = ~clk;

  demux4x32_reg_if #(.WIDTH(32), .CNT_W(16)) ifm ();
  demux4x32_reg_if #(.WIDTH(32), .CNT_W(4))  ifs ();

  // the narrow-counter instance mirrors the main instance's stimulus
  assign ifs.in_valid  = ifm.in_valid;
  assign ifs.in_data   = ifm.in_data;
  assign ifs.in_sel    = ifm.in_sel;
  assign ifs.out_ready = ifm.out_ready;

  demux4x32_reg #(.WIDTH(32), .CNT_W(16)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (ifm)
  );

  demux4x32_reg #(.WIDTH(32), .CNT_W(4)) dut_narrow (
    .clk  (clk),
    .clrn (clrn),
    .bus  (ifs)
  );

  logic [31:0] sb_q [4][$];
  int          sb_cnt [4];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          verbose = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_data(input int k);
    case (k)
      0:       return ifm.out_data0;
      1:       return ifm.out_data1;
      2:       return ifm.out_data2;
      default: return ifm.out_data3;
    endcase
  endfunction

  function automatic logic [15:0] obs_cnt(input int k);
    case (k)
      0:       return ifm.xfer_cnt0;
      1:       return ifm.xfer_cnt1;
      2:       return ifm.xfer_cnt2;
      default: return ifm.xfer_cnt3;
    endcase
  endfunction

  function automatic logic [3:0] obs_cnt_narrow(input int k);
    case (k)
      0:       return ifs.xfer_cnt0;
      1:       return ifs.xfer_cnt1;
      2:       return ifs.xfer_cnt2;
      default: return ifs.xfer_cnt3;
    endcase
  endfunction

  task automatic sb_reset();
    for (int k = 0; k < 4; k++) begin
      sb_q[k].delete();
      sb_cnt[k] = 0;
    end
  endtask

  // One clock cycle. It drives at posedge+1 and samples at the negedge.
  // It then updates the scoreboard and returns at the next posedge+1.
  task automatic step(input bit v, input bit [1:0] s, input bit [31:0] d, input bit [3:0] r);
    bit exp_rdy;
    bit exp_v;
    ifm.in_valid  = v;
    ifm.in_sel    = s;
    ifm.in_data   = d;
    ifm.out_ready = r;
    @(negedge clk);
    exp_rdy = (sb_q[s].size() == 0) || r[s];
    check_eq("in_ready", 64'(ifm.in_ready), 64'(exp_rdy));
    for (int k = 0; k < 4; k++) begin
      exp_v = (sb_q[k].size() != 0);
      check_eq($sformatf("out_valid%0d", k), 64'(ifm.out_valid[k]), 64'(exp_v));
      check_eq($sformatf("xfer_cnt%0d", k), 64'(obs_cnt(k)), 64'(sb_cnt[k] & 32'hFFFF));
      check_eq($sformatf("xfer_cnt%0d_w4", k), 64'(obs_cnt_narrow(k)), 64'(sb_cnt[k] & 32'hF));
      if (exp_v) begin
        check_eq($sformatf("out_data%0d", k), 64'(obs_data(k)), 64'(sb_q[k][0]));
        if (r[k]) begin
          if (verbose) $display("[%0t] drain  ch%0d data=%08h", $time, k, sb_q[k][0]);
          void'(sb_q[k].pop_front());
          sb_cnt[k]++;
        end
      end
    end
    if (v && exp_rdy) begin
      if (verbose) $display("[%0t] accept ch%0d data=%08h", $time, s, d);
      sb_q[s].push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn          = 1'b0;
    ifm.in_valid  = 1'b0;
    ifm.in_sel    = 2'd0;
    ifm.in_data   = 32'd0;
    ifm.out_ready = 4'b0000;
    sb_reset();

    // reset state while clrn is held low
    #1;
    ifm.in_valid = 1'b1;
    #1;
    check_eq("rst_out_valid", 64'(ifm.out_valid), 64'h0);
    check_eq("rst_in_ready", 64'(ifm.in_ready), 64'h0);
    check_eq("rst_out_data0", 64'(ifm.out_data0), 64'h0);
    check_eq("rst_out_data3", 64'(ifm.out_data3), 64'h0);
    check_eq("rst_xfer_cnt1", 64'(ifm.xfer_cnt1), 64'h0);
    ifm.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // single word to channel 2, held through 5 stall cycles, then drained
    step(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    repeat (5) step(1'b0, 2'd0, 32'h0, 4'b0000);
    step(1'b0, 2'd0, 32'h0, 4'b0100);
    step(1'b0, 2'd0, 32'h0, 4'b0000);

    // backpressure on channel 1 does not block channel 3
    step(1'b1, 2'd1, 32'h11110001, 4'b0000);
    step(1'b1, 2'd1, 32'h11110002, 4'b0000);
    step(1'b1, 2'd3, 32'h33330001, 4'b0000);
    step(1'b0, 2'd0, 32'h0, 4'b0000);

    // asynchronous reset mid-run with channels 1 and 3 full
    check_eq("pre_rst_valid", 64'(ifm.out_valid), 64'hA);
    ifm.in_valid = 1'b1;
    ifm.in_sel   = 2'd0;
    #2;
    clrn = 1'b0;
    #1;
    check_eq("async_out_valid", 64'(ifm.out_valid), 64'h0);
    check_eq("async_cnt2", 64'(ifm.xfer_cnt2), 64'h0);
    check_eq("async_in_ready", 64'(ifm.in_ready), 64'h0);
    check_eq("async_out_data1", 64'(ifm.out_data1), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("held_rst_in_ready", 64'(ifm.in_ready), 64'h0);
    check_eq("held_rst_out_valid", 64'(ifm.out_valid), 64'h0);
    ifm.in_valid = 1'b0;
    sb_reset();
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // streaming: 8 back-to-back words on channel 0
    for (int i = 1; i <= 8; i++) step(1'b1, 2'd0, 32'(i), 4'b1111);
    step(1'b0, 2'd0, 32'h0, 4'b1111);
    check_eq("stream_cnt0", 64'(ifm.xfer_cnt0), 64'd8);

    // counter wrap on the 4-bit instance: 17 drains on channel 2
    for (int i = 0; i < 17; i++) step(1'b1, 2'd2, 32'hC0DE0000 + 32'(i), 4'b1111);
    step(1'b0, 2'd0, 32'h0, 4'b1111);
    check_eq("wrap_cnt2_w4", 64'(ifs.xfer_cnt2), 64'd1);
    check_eq("wrap_cnt2_w16", 64'(ifm.xfer_cnt2), 64'd17);

    // random traffic against the scoreboard
    verbose = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(),
           4'($urandom_range(0, 15)));
    end
    step(1'b0, 2'd0, 32'h0, 4'b1111);
    step(1'b0, 2'd0, 32'h0, 4'b1111);
    check_eq("final_empty", 64'(ifm.out_valid), 64'h0);
    $display("[%0t] random phase done: delivered ch0=%0d ch1=%0d ch2=%0d ch3=%0d",
             $time, sb_cnt[0], sb_cnt[1], sb_cnt[2], sb_cnt[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
